adc_frame_rx: RTL and testbench

ADC_FRAME_RX -- requirements
Module: adc_frame_rx

---
 rtl/adc_frame_rx_pkg.sv | 20 ++
 rtl/adc_frame_fifo.sv | 50 +++++
 rtl/adc_frame_rx.sv | 153 +++++++++++++++
 tb/tb_adc_frame_rx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_frame_rx_pkg.sv
// Shared types and constants for the ADC frame receiver.
// The frame typedefs describe the default 8-way x 9-bit geometry.
package adc_frame_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StRun
  } state_e;

  localparam int unsigned CntWidth = 16;
  localparam int unsigned SeqWidth = 8;

  localparam int unsigned DefWays = 8;
  localparam int unsigned DefBits = 9;

  typedef logic [DefBits-1:0]         sample_t;
  typedef logic [DefWays*DefBits-1:0] frame_t;

endpackage

// File: rtl/adc_frame_fifo.sv
// First-word fall-through frame FIFO; a push into a full FIFO is accepted only
// when a pop happens on the same edge.
module adc_frame_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == (PtrW+1)'(DEPTH));
  assign w_pop   = i_pop && o_valid;
  assign w_push  = i_push && (!o_full || w_pop);
  // Head is masked when empty so the output reads zero after reset.
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/adc_frame_rx.sv
// Interleaved ADC frame receiver: capture, offset-correct and saturate each lane,
// then queue frames with a sequence number for a ready/valid consumer.
module adc_frame_rx
  import adc_frame_rx_pkg::*;
#(
  parameter int unsigned ADC_WAYS     = 8,
  parameter int unsigned ADC_BITS     = 9,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned FLUSH_FRAMES = 2,
  localparam int unsigned WAY_W       = (ADC_WAYS > 1) ? $clog2(ADC_WAYS) : 1,
  localparam int unsigned FRAME_W     = ADC_WAYS * ADC_BITS
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [FRAME_W-1:0]  i_adc_data,
  input  logic                i_ofs_wr,
  input  logic [WAY_W-1:0]    i_ofs_way,
  input  logic [ADC_BITS-1:0] i_ofs_val,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [FRAME_W-1:0]  o_out_data,
  output logic [SeqWidth-1:0] o_out_seq,
  output logic [CntWidth-1:0] o_ovr_cnt,
  output logic [CntWidth-1:0] o_drop_cnt,
  input  logic                i_cnt_clr
);

  state_e                r_state;
  logic [7:0]            r_flush_cnt;
  logic [SeqWidth-1:0]   r_seq;
  logic [FRAME_W-1:0]    r_s1_data;
  logic                  r_s1_vld;
  logic [FRAME_W-1:0]    r_s2_data;
  logic                  r_s2_vld;
  logic                  r_s2_ovr;
  logic [ADC_BITS-1:0]   r_ofs [ADC_WAYS];
  logic [CntWidth-1:0]   r_ovr_cnt;
  logic [CntWidth-1:0]   r_drop_cnt;

  logic [FRAME_W-1:0]    w_corr;
  logic [ADC_WAYS-1:0]   w_lane_ovr;
  logic                  w_fifo_full;
  logic                  w_fifo_valid;
  logic                  w_pop;
  logic                  w_drop;
  logic [SeqWidth+FRAME_W-1:0] w_fifo_out;

  // The edge that leaves IDLE already discards the first flush frame.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_flush_cnt <= '0;
      r_seq       <= '0;
    end else begin
      if (r_s2_vld) r_seq <= r_seq + 1'b1;
      if (!i_en) begin
        r_state <= StIdle;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_state     <= StFlush;
            r_flush_cnt <= 8'd1;
            r_seq       <= '0;
          end
          StFlush: begin
            if ({24'd0, r_flush_cnt} + 32'd1 >= FLUSH_FRAMES) r_state <= StRun;
            else r_flush_cnt <= r_flush_cnt + 8'd1;
          end
          StRun:   r_state <= StRun;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_data <= '0;
      r_s1_vld  <= 1'b0;
      r_s2_data <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_ovr  <= 1'b0;
    end else begin
      if (i_en) r_s1_data <= i_adc_data;
      r_s1_vld <= i_en && (r_state == StRun);
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_data <= w_corr;
        r_s2_ovr  <= |w_lane_ovr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int w = 0; w < ADC_WAYS; w++) r_ofs[w] <= '0;
    end else begin
      for (int w = 0; w < ADC_WAYS; w++) begin
        if (i_ofs_wr && (i_ofs_way == WAY_W'(w))) r_ofs[w] <= i_ofs_val;
      end
    end
  end

  // Offset binary to two's complement is an MSB flip; the extra bit keeps the
  // difference exact so saturation can be decided from the top two bits.
  for (genvar g = 0; g < ADC_WAYS; g++) begin : g_lane
    logic [ADC_BITS-1:0]      w_raw;
    logic signed [ADC_BITS:0] w_diff;

    assign w_raw  = r_s1_data[g*ADC_BITS +: ADC_BITS];
    assign w_diff = $signed({{2{~w_raw[ADC_BITS-1]}}, w_raw[ADC_BITS-2:0]})
                  - $signed({r_ofs[g][ADC_BITS-1], r_ofs[g]});
    assign w_corr[g*ADC_BITS +: ADC_BITS] = (w_diff[ADC_BITS] == w_diff[ADC_BITS-1])
        ? w_diff[ADC_BITS-1:0]
        : {w_diff[ADC_BITS], {(ADC_BITS-1){~w_diff[ADC_BITS]}}};
    assign w_lane_ovr[g] = (&w_raw) | ~(|w_raw);
  end

  assign w_pop  = i_out_ready && w_fifo_valid;
  assign w_drop = r_s2_vld && w_fifo_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_cnt_clr) begin
      r_ovr_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (r_s2_vld && r_s2_ovr && (r_ovr_cnt != '1)) r_ovr_cnt <= r_ovr_cnt + 1'b1;
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  adc_frame_fifo #(
    .WIDTH (SeqWidth + FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (r_s2_vld),
    .i_data  ({r_seq, r_s2_data}),
    .i_pop   (w_pop),
    .o_full  (w_fifo_full),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_out)
  );

  assign o_out_valid = w_fifo_valid;
  assign o_out_data  = w_fifo_out[FRAME_W-1:0];
  assign o_out_seq   = w_fifo_out[FRAME_W +: SeqWidth];
  assign o_ovr_cnt   = r_ovr_cnt;
  assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_adc_frame_rx.sv
// Bench for adc_frame_rx: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the frame stream.
module tb_adc_frame_rx;

  localparam int W  = 8;
  localparam int B  = 9;
  localparam int D  = 4;
  localparam int F  = 2;
  localparam int FW = W * B;

  logic          clk = 1'b0;
  logic          rst_n, en, ofs_wr, out_ready, cnt_clr;
  logic [FW-1:0] adc_data;
  logic [2:0]    ofs_way;
  logic [B-1:0]  ofs_val;
  logic          out_valid;
  logic [FW-1:0] out_data;
  logic [7:0]    out_seq;
  logic [15:0]   ovr_cnt, drop_cnt;

  always #5 clk = ~clk;

  adc_frame_rx #(
    .ADC_WAYS     (W),
    .ADC_BITS     (B),
    .FIFO_DEPTH   (D),
    .FLUSH_FRAMES (F)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_adc_data  (adc_data),
    .i_ofs_wr    (ofs_wr),
    .i_ofs_way   (ofs_way),
    .i_ofs_val   (ofs_val),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_seq   (out_seq),
    .o_ovr_cnt   (ovr_cnt),
    .o_drop_cnt  (drop_cnt),
    .i_cnt_clr   (cnt_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [FW-1:0] act,
                            input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: frames in flight with their push edge, plus the FIFO contents.
  typedef struct { logic [FW-1:0] data; bit ovr; longint due; } pend_t;
  typedef struct { logic [FW-1:0] data; logic [7:0] seq; } ent_t;

  pend_t  pend_q[$];
  ent_t   fifo_q[$];
  int     m_ofs[W];
  int     m_seq, m_ovr, m_drop, run_idx;
  longint edge_n = 0;

  function automatic void correct(input logic [FW-1:0] raw, output logic [FW-1:0] res,
                                  output bit ovr);
    int half = 1 << (B - 1);
    res = '0;
    ovr = 1'b0;
    for (int w = 0; w < W; w++) begin
      int code = int'(raw[w*B +: B]);
      int v = code - half - m_ofs[w];
      if (v > half - 1) v = half - 1;
      if (v < -half) v = -half;
      res[w*B +: B] = B'(v);
      if (code == 0 || code == (1 << B) - 1) ovr = 1'b1;
    end
  endfunction

  task automatic model_step();
    bit    full, pop, ovr_inc, drop_inc;
    pend_t p;
    ent_t  e;
    if (!rst_n) begin
      pend_q.delete();
      fifo_q.delete();
      foreach (m_ofs[i]) m_ofs[i] = 0;
      m_seq = 0; m_ovr = 0; m_drop = 0; run_idx = 0;
    end else begin
      full = (fifo_q.size() == D);
      pop  = (fifo_q.size() > 0) && out_ready;
      ovr_inc = 1'b0; drop_inc = 1'b0;
      if (pop) void'(fifo_q.pop_front());
      if (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
        p = pend_q.pop_front();
        ovr_inc = p.ovr;
        if (!full || pop) begin
          e.data = p.data;
          e.seq  = 8'(m_seq);
          fifo_q.push_back(e);
        end else begin
          drop_inc = 1'b1;
        end
        m_seq = (m_seq + 1) % 256;
      end
      if (cnt_clr) begin
        m_ovr = 0; m_drop = 0;
      end else begin
        if (ovr_inc && m_ovr < 65535) m_ovr++;
        if (drop_inc && m_drop < 65535) m_drop++;
      end
      if (ofs_wr) m_ofs[ofs_way] = int'($signed(ofs_val));
      if (en) begin
        if (run_idx >= F) begin
          correct(adc_data, p.data, p.ovr);
          p.due = edge_n + 2;
          pend_q.push_back(p);
        end
        if (run_idx == 0) m_seq = 0;
        run_idx++;
      end else begin
        run_idx = 0;
      end
    end
    edge_n++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("valid", 64'(out_valid), 64'(fifo_q.size() > 0));
    if (fifo_q.size() > 0) begin
      check_data("data", out_data, fifo_q[0].data);
      check("seq", 64'(out_seq), 64'(fifo_q[0].seq));
    end
    check("ovr_cnt", 64'(ovr_cnt), 64'(m_ovr));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [FW-1:0] all_mid, frame, expv;
  int t;
  int exp_seq[6] = '{1, 2, 3, 10, 11, 12};

  initial begin
    for (int w = 0; w < W; w++) all_mid[w*B +: B] = 9'h100;
    rst_n = 1'b0; en = 1'b0; adc_data = all_mid; ofs_wr = 1'b0; ofs_way = '0;
    ofs_val = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    tick(); tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check_data("rst_data", out_data, '0);
    check("rst_seq", 64'(out_seq), 64'd0);
    check("rst_ovr", 64'(ovr_cnt), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);

    // Mid-scale code, zero offsets: two flush frames, then zeros.
    rst_n = 1'b1; en = 1'b1;
    t = 0;
    while (!out_valid && t < 20) begin tick(); t++; end
    check("first_latency", 64'(t), 64'd5);
    check_data("mid_zero", out_data, '0);
    check("seq_first", 64'(out_seq), 64'd0);
    tick(); check("seq_second", 64'(out_seq), 64'd1);
    tick(); check("seq_third", 64'(out_seq), 64'd2);

    // Lane 3 at full scale with offset -5 saturates high and flags overrange.
    frame = all_mid; frame[3*B +: B] = 9'h1FF; adc_data = frame;
    ofs_wr = 1'b1; ofs_way = 3'd3; ofs_val = 9'h1FB;
    tick(); ofs_wr = 1'b0;
    repeat (3) tick();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    repeat (5) tick();
    check("ovr_five", 64'(ovr_cnt), 64'd5);
    expv = '0; expv[3*B +: B] = 9'h0FF;
    check_data("lane3_sat", out_data, expv);

    // Stalled consumer over 10 RUN frames, then continuous draining.
    en = 1'b0; adc_data = all_mid;
    ofs_wr = 1'b1; ofs_way = 3'd3; ofs_val = '0;
    tick(); ofs_wr = 1'b0;
    repeat (4) tick();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    out_ready = 1'b0; en = 1'b1;
    repeat (14) tick();
    check("stall_drop", 64'(drop_cnt), 64'd6);
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_head", 64'(out_seq), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("drain_seq", 64'(out_seq), 64'(exp_seq[i]));
    end
    check("drain_nodrop", 64'(drop_cnt), 64'd6);

    // Reset while three frames are buffered.
    en = 1'b0;
    repeat (10) tick();
    ofs_wr = 1'b1; ofs_way = 3'd0; ofs_val = 9'd7;
    tick(); ofs_wr = 1'b0;
    out_ready = 1'b0; en = 1'b1;
    repeat (5) tick();
    en = 1'b0;
    repeat (2) tick();
    expv = '0; expv[0 +: B] = 9'h1F9;
    check_data("ofs_lane0", out_data, expv);
    rst_n = 1'b0; tick();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ovr", 64'(ovr_cnt), 64'd0);
    check("mid_rst_drop", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1; out_ready = 1'b1; en = 1'b1;
    t = 0;
    while (!out_valid && t < 20) begin tick(); t++; end
    check("post_rst_latency", 64'(t), 64'd5);
    check_data("post_rst_ofs_zero", out_data, '0);

    // Random traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      en        = ($urandom_range(0, 19) != 0);
      out_ready = ((i / 200) % 2 == 0) ? 1'($urandom_range(0, 1))
                                       : ($urandom_range(0, 4) != 0);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      ofs_wr    = ($urandom_range(0, 9) == 0);
      ofs_way   = 3'($urandom);
      ofs_val   = 9'($urandom);
      for (int w = 0; w < W; w++) begin
        case ($urandom_range(0, 9))
          0:       adc_data[w*B +: B] = '0;
          1:       adc_data[w*B +: B] = '1;
          default: adc_data[w*B +: B] = 9'($urandom);
        endcase
      end
      tick();
    end

    en = 1'b0; rst_n = 1'b1;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
